// File: rtl/axi_pkg.sv
// Shared AXI definitions used by the AXI-Lite peripherals.
// Response codes are the subset these slaves ever return.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

endpackage

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave fronting a single-port BRAM, one transaction in flight.
// Writes and reads share the RAM port; ties alternate between the two.
module axi_lite_bram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          bram_en,
    output logic [DATA_WIDTH/8-1:0]       bram_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_wrdata,
    input  logic [DATA_WIDTH-1:0]         bram_rddata
);

    import axi_pkg::*;

    localparam int WA = $clog2(MEM_DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    // Byte-address bits above the RAM window; all zero when the bus is no wider.
    localparam logic [ADDR_WIDTH-1:0] HI_MASK =
        ~ADDR_WIDTH'((64'd1 << (WA + 2)) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        WR_RESP,
        RD_CAP,
        RD_RESP
    } state_e;

    state_e r_state;
    state_e w_next;

    logic                  r_live;
    logic                  r_last_wr;
    logic                  r_rd_err;
    axi_resp_e             r_bresp;
    axi_resp_e             r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_wr_req;
    logic w_rd_req;
    logic w_aw_oor;
    logic w_ar_oor;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_unused;

    assign w_wr_req = s_axi_awvalid & s_axi_wvalid;
    assign w_rd_req = s_axi_arvalid;
    assign w_aw_oor = |(s_axi_awaddr & HI_MASK);
    assign w_ar_oor = |(s_axi_araddr & HI_MASK);
    assign w_unused = ^{s_axi_awprot, s_axi_arprot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            IDLE: begin
                // r_live keeps every ready low in the first cycle out of reset.
                if (r_live) begin
                    if (w_wr_req && (!w_rd_req || !r_last_wr)) begin
                        w_grant_wr = 1'b1;
                        w_next     = WR_RESP;
                    end else if (w_rd_req) begin
                        w_grant_rd = 1'b1;
                        w_next     = RD_CAP;
                    end
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    w_next = IDLE;
                end
            end
            RD_CAP: begin
                w_next = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_last_wr <= 1'b0;
            r_rd_err  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_grant_wr) begin
                r_last_wr <= 1'b1;
                r_bresp   <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_grant_rd) begin
                r_last_wr <= 1'b0;
                r_rd_err  <= w_ar_oor;
                r_rresp   <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_state == RD_CAP) begin
                r_rdata <= r_rd_err ? '0 : bram_rddata;
            end
        end
    end

    assign s_axi_awready = w_grant_wr;
    assign s_axi_wready  = w_grant_wr;
    assign s_axi_arready = w_grant_rd;
    assign s_axi_bvalid  = (r_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_state == RD_RESP);
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    assign bram_en     = (w_grant_wr & ~w_aw_oor) | (w_grant_rd & ~w_ar_oor);
    assign bram_we     = (w_grant_wr & ~w_aw_oor) ? s_axi_wstrb : {SW{1'b0}};
    assign bram_addr   = w_grant_wr ? s_axi_awaddr[WA+1:2] : s_axi_araddr[WA+1:2];
    assign bram_wrdata = s_axi_wdata;

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Bench for axi_lite_bram_ctrl: directed table, corner sequences,
// then random traffic against a word-array reference memory.
module tb_axi_lite_bram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4096;
    localparam int WA    = 12;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            bram_en;
    logic [DW/8-1:0] bram_we;
    logic [WA-1:0]   bram_addr;
    logic [DW-1:0]   bram_wrdata;
    logic [DW-1:0]   bram_rddata;

    axi_lite_bram_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wrdata   (bram_wrdata),
        .bram_rddata   (bram_rddata)
    );

    // Single-port RAM beside the controller: byte-enabled write, registered read.
    logic [DW-1:0] ram [DEPTH];

    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) ram[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
            end
            bram_rddata <= ram[bram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [DEPTH];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input int wdly, input int bdly);
        int  n;
        bit  ok;
        ok = (exp_resp == OKAY);
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        bready  = 1'b0;
        for (int i = 0; i < wdly; i++) begin
            #1;
            chk("aw_only_no_ready", {awready, wready, arready}, 3'b000);
            chk("aw_only_no_ram", bram_en, 1'b0);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("aw_handshake", {awready, wready}, 2'b11);
        chk("wr_bram_en", bram_en, ok);
        chk("wr_bram_we", bram_we, ok ? strb : 4'h0);
        if (ok) begin
            chk("wr_bram_addr", bram_addr, addr[13:2]);
            chk("wr_bram_data", bram_wrdata, data);
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #1;
        chk("bvalid_t1", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
        chk("wr_resp_no_ram", bram_en, 1'b0);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", {bvalid, bresp}, {1'b1, exp_resp});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[addr[13:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [1:0] exp_resp,
                            input logic [31:0] exp_data, input int rdly);
        int n;
        bit ok;
        ok = (exp_resp == OKAY);
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ar_handshake", arready, 1'b1);
        chk("rd_bram_en", bram_en, ok);
        chk("rd_bram_we", bram_we, 4'h0);
        if (ok) chk("rd_bram_addr", bram_addr, addr[13:2]);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("rvalid_early", rvalid, 1'b0);
        chk("rd_cap_no_ram", bram_en, 1'b0);
        @(negedge clk);
        chk("rvalid_t2", rvalid, 1'b1);
        chk("rdata", rdata, exp_data);
        chk("rresp", rresp, exp_resp);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 1'b0);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          gcyc [$];
        string       gkind [$];
        int          rv_seen;

        vecs[0]  = '{1, 16'h0010, 32'hDEADBEEF, 4'hF, OKAY,   32'h0};
        vecs[1]  = '{0, 16'h0010, 32'h0,        4'h0, OKAY,   32'hDEADBEEF};
        vecs[2]  = '{1, 16'h0020, 32'h11223344, 4'hF, OKAY,   32'h0};
        vecs[3]  = '{1, 16'h0020, 32'h000000AA, 4'h1, OKAY,   32'h0};
        vecs[4]  = '{0, 16'h0020, 32'h0,        4'h0, OKAY,   32'h112233AA};
        vecs[5]  = '{0, 16'h0023, 32'h0,        4'h0, OKAY,   32'h112233AA};
        vecs[6]  = '{0, 16'h4000, 32'h0,        4'h0, SLVERR, 32'h0};
        vecs[7]  = '{1, 16'h4020, 32'hFFFFFFFF, 4'hF, SLVERR, 32'h0};
        vecs[8]  = '{0, 16'h0020, 32'h0,        4'h0, OKAY,   32'h112233AA};
        vecs[9]  = '{1, 16'h3FFC, 32'hCAFEF00D, 4'hF, OKAY,   32'h0};
        vecs[10] = '{0, 16'h3FFC, 32'h0,        4'h0, OKAY,   32'hCAFEF00D};
        vecs[11] = '{1, 16'h0011, 32'h12345678, 4'hA, OKAY,   32'h0};
        vecs[12] = '{0, 16'h0010, 32'h0,        4'h0, OKAY,   32'h12AD56EF};

        rst_n   = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_bram", {bram_en, bram_we}, 5'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 0, 0);
            else
                axi_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata, 0);
            if (i == 0) chk("ram_word4", ram[4], 32'hDEADBEEF);
            if (i == 7) chk("ram_word8_kept", ram[8], 32'h112233AA);
        end

        // awvalid alone for 5 cycles, then bready withheld for 4.
        axi_write(16'h0030, 32'h55AA33CC, 4'hF, OKAY, 5, 4);
        axi_read(16'h0030, OKAY, 32'h55AA33CC, 3);

        // Fresh reset so the first tie must go to write, then alternate.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        awaddr  = 16'h0040;
        wdata   = 32'h0BADF00D;
        wstrb   = 4'hF;
        araddr  = 16'h0040;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        bready  = 1'b1;
        rready  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (awready && arready) chk("arb_exclusive", 1'b1, 1'b0);
            if (awready) begin
                gcyc.push_back(c);
                gkind.push_back("W");
            end else if (arready) begin
                gcyc.push_back(c);
                gkind.push_back("R");
            end
            if (rvalid) chk("arb_rdata", rdata, 32'h0BADF00D);
            if (c < 9) @(negedge clk);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(negedge clk);
        bready = 1'b0;
        rready = 1'b0;
        ref_mem[16] = 32'h0BADF00D;
        chk("arb_grants", gcyc.size(), 4);
        if (gcyc.size() == 4) begin
            chk("arb_order", {gkind[0] == "W", gkind[1] == "R", gkind[2] == "W", gkind[3] == "R"}, 4'hF);
            chk("arb_cycles", {gcyc[0][7:0], gcyc[1][7:0], gcyc[2][7:0], gcyc[3][7:0]}, 32'h00020507);
        end

        // Reset while the read sits in RD_CAP.
        @(negedge clk);
        araddr  = 16'h0010;
        arvalid = 1'b1;
        #1;
        chk("rc_ar_grant", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rc_outputs", {rvalid, bvalid, arready, awready, bram_en, bram_we}, 9'h0);
        chk("rc_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        arvalid = 1'b1;
        rst_n   = 1'b1;
        #1;
        chk("rel_ready_low", {arready, awready, wready}, 3'b000);
        arvalid = 1'b0;
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid || bvalid) rv_seen++;
        end
        chk("rc_no_resp", rv_seen, 0);
        axi_read(16'h0010, OKAY, ref_mem[4], 0);

        // Random traffic: prime a 64-word window, then mixed ops.
        for (int i = 0; i < 64; i++) begin
            axi_write(16'(i * 4), $urandom, 4'hF, OKAY, 0, 0);
        end
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a[15:14] = 2'($urandom_range(1, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, d, s, (a[15:14] != 0) ? SLVERR : OKAY, 0,
                          $urandom_range(0, 2));
            else
                axi_read(a, (a[15:14] != 0) ? SLVERR : OKAY,
                         (a[15:14] != 0) ? 32'h0 : ref_mem[a[13:2]],
                         $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
